// File: rtl/alu_regfile.sv
// alu_regfile: 4 x 16-bit register file with write-through bypass
// plus a combinational 8-function ALU with signed-overflow flag.
module alu_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  reg_write,
    input  logic [AW-1:0]         read_addr1,
    input  logic [AW-1:0]         read_addr2,
    input  logic [AW-1:0]         write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic [DATA_WIDTH-1:0] alu_a,
    input  logic [DATA_WIDTH-1:0] alu_b,
    input  logic [2:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  alu_overflow
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_ORR = 3'd3,
        OP_NOT = 3'd4,
        OP_TCP = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_wr_live;
    logic                  w_byp1;
    logic                  w_byp2;
    alu_op_e               w_op;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_sign_a;
    logic                  w_sign_b;

    // A write is only real when not held in reset; this also gates the bypass.
    assign w_wr_live = reg_write & Reset_N;
    assign w_byp1    = w_wr_live & (write_addr == read_addr1);
    assign w_byp2    = w_wr_live & (write_addr == read_addr2);

    // Register file state: synchronous clear has priority over writes.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (reg_write) begin
            r_regs[write_addr] <= write_data;
        end
    end

    // Read ports with WB->ID write-through bypass.
    always_comb begin
        read_data1 = r_regs[read_addr1];
        read_data2 = r_regs[read_addr2];
        if (w_byp1) begin
            read_data1 = write_data;
        end
        if (w_byp2) begin
            read_data2 = write_data;
        end
    end

    assign w_op     = alu_op_e'(alu_op);
    assign w_sum    = alu_a + alu_b;
    assign w_diff   = alu_a - alu_b;
    assign w_sign_a = alu_a[DATA_WIDTH-1];
    assign w_sign_b = alu_b[DATA_WIDTH-1];

    // ALU function select and signed-overflow detection.
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        unique case (w_op)
            OP_ADD: begin
                alu_result   = w_sum;
                alu_overflow = (w_sign_a == w_sign_b) &&
                               (w_sum[DATA_WIDTH-1] != w_sign_a);
            end
            OP_SUB: begin
                alu_result   = w_diff;
                alu_overflow = (w_sign_a != w_sign_b) &&
                               (w_diff[DATA_WIDTH-1] != w_sign_a);
            end
            OP_AND: alu_result = alu_a & alu_b;
            OP_ORR: alu_result = alu_a | alu_b;
            OP_NOT: alu_result = ~alu_a;
            OP_TCP: alu_result = '0 - alu_a;
            OP_SHL: alu_result = {alu_a[DATA_WIDTH-2:0], 1'b0};
            OP_SHR: alu_result = {w_sign_a, alu_a[DATA_WIDTH-1:1]};
            default: begin
                alu_result   = '0;
                alu_overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed plan plus randomized traffic checked
// against an array/integer-arithmetic reference model.
module tb_alu_regfile;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        reg_write;
    logic [1:0]  read_addr1;
    logic [1:0]  read_addr2;
    logic [1:0]  write_addr;
    logic [15:0] write_data;
    logic [15:0] read_data1;
    logic [15:0] read_data2;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_overflow;

    logic [15:0] m_regs [4];
    int total = 0;
    int bad   = 0;

    alu_regfile dut (
        .Clk          (Clk),
        .Reset_N      (Reset_N),
        .reg_write    (reg_write),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_alu(input logic [2:0] op,
                                    input logic [15:0] a,
                                    input logic [15:0] b,
                                    output logic [15:0] r,
                                    output logic v);
        int sa;
        int sb;
        int x;
        sa = int'($signed(a));
        sb = int'($signed(b));
        x  = 0;
        v  = 1'b0;
        case (op)
            3'd0: begin
                x = sa + sb;
                v = (x > 32767) || (x < -32768);
            end
            3'd1: begin
                x = sa - sb;
                v = (x > 32767) || (x < -32768);
            end
            3'd2: x = int'(a & b);
            3'd3: x = int'(a | b);
            3'd4: x = -sa - 1;
            3'd5: x = -sa;
            3'd6: x = sa * 2;
            default: x = sa >>> 1;
        endcase
        r = x[15:0];
    endfunction

    function automatic logic [15:0] ref_rd(input logic [1:0] ra);
        if (reg_write && Reset_N && write_addr == ra) return write_data;
        return m_regs[ra];
    endfunction

    task automatic step(input logic rn, input logic we,
                        input logic [1:0] wa, input logic [15:0] wd,
                        input logic [1:0] ra1, input logic [1:0] ra2,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op);
        logic [15:0] er;
        logic        ev;
        @(negedge Clk);
        Reset_N    = rn;
        reg_write  = we;
        write_addr = wa;
        write_data = wd;
        read_addr1 = ra1;
        read_addr2 = ra2;
        alu_a      = a;
        alu_b      = b;
        alu_op     = op;
        #1;
        chk("m_rd1", read_data1, ref_rd(ra1));
        chk("m_rd2", read_data2, ref_rd(ra2));
        ref_alu(op, a, b, er, ev);
        chk("m_alu", alu_result, er);
        chk("m_ovf", {15'd0, alu_overflow}, {15'd0, ev});
    endtask

    task automatic tick();
        @(posedge Clk);
        if (!Reset_N) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
        end else if (reg_write) begin
            m_regs[write_addr] = write_data;
        end
        #1;
    endtask

    task automatic alu_case(input string tag, input logic [2:0] op,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] er, input logic ev);
        step(1, 0, 0, 0, 0, 1, a, b, op);
        chk(tag, alu_result, er);
        chk({tag, "_ovf"}, {15'd0, alu_overflow}, {15'd0, ev});
        tick();
    endtask

    initial begin
        Reset_N    = 1'b0;
        reg_write  = 1'b0;
        write_addr = '0;
        write_data = '0;
        read_addr1 = '0;
        read_addr2 = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = '0;
        @(negedge Clk);
        tick();
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;

        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("rst_r0", read_data1, 16'h0000);
        chk("rst_r1", read_data2, 16'h0000);
        tick();
        step(1, 0, 0, 0, 2, 3, 0, 0, 0);
        chk("rst_r2", read_data1, 16'h0000);
        chk("rst_r3", read_data2, 16'h0000);
        tick();
        step(0, 1, 2, 16'h1234, 2, 2, 0, 0, 0);
        chk("rst_nobyp", read_data1, 16'h0000);
        tick();
        step(1, 0, 0, 0, 2, 2, 0, 0, 0);
        chk("rst_nowr", read_data1, 16'h0000);
        tick();

        step(1, 1, 0, 16'h0001, 0, 0, 0, 0, 0); tick();
        step(1, 1, 1, 16'h00FF, 0, 0, 0, 0, 0); tick();
        step(1, 1, 2, 16'h8000, 0, 0, 0, 0, 0); tick();
        step(1, 1, 3, 16'hFFFF, 0, 0, 0, 0, 0); tick();
        step(1, 0, 0, 0, 0, 3, 0, 0, 0);
        chk("rd_r0", read_data1, 16'h0001);
        chk("rd_r3", read_data2, 16'hFFFF);
        tick();
        step(1, 0, 0, 16'h5555, 1, 2, 0, 0, 0);
        chk("rd_r1", read_data1, 16'h00FF);
        chk("rd_r2", read_data2, 16'h8000);
        tick();
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("nowe_r0", read_data1, 16'h0001);
        tick();

        step(1, 1, 1, 16'h0007, 0, 0, 0, 0, 0); tick();
        step(1, 1, 1, 16'h00AA, 1, 1, 0, 0, 0);
        chk("byp1", read_data1, 16'h00AA);
        chk("byp2", read_data2, 16'h00AA);
        tick();
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("byp_wr", read_data1, 16'h00AA);
        tick();

        alu_case("add_ovf", 0, 16'h7FFF, 16'h0001, 16'h8000, 1);
        alu_case("add_wrap", 0, 16'hFFFF, 16'h0001, 16'h0000, 0);
        alu_case("sub_ovf", 1, 16'h8000, 16'h0001, 16'h7FFF, 1);
        alu_case("sub_neg", 1, 16'h0005, 16'h0007, 16'hFFFE, 0);
        alu_case("and", 2, 16'hF0F0, 16'h0FF0, 16'h00F0, 0);
        alu_case("orr", 3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 0);
        alu_case("not", 4, 16'hF0F0, 16'h0FF0, 16'h0F0F, 0);
        alu_case("tcp", 5, 16'hF0F0, 16'h0FF0, 16'h0F10, 0);
        alu_case("shl", 6, 16'hF0F0, 16'h0FF0, 16'hE1E0, 0);
        alu_case("shr", 7, 16'hF0F0, 16'h0FF0, 16'hF878, 0);
        alu_case("tcp_min", 5, 16'h8000, 16'h1234, 16'h8000, 0);

        step(1, 1, 3, 16'h2222, 0, 0, 0, 0, 0); tick();
        step(0, 1, 3, 16'hABCD, 3, 3, 0, 0, 0);
        chk("mid_nobyp", read_data1, 16'h2222);
        tick();
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("mid_r0", read_data1, 16'h0000);
        chk("mid_r1", read_data2, 16'h0000);
        tick();
        step(1, 0, 0, 0, 2, 3, 0, 0, 0);
        chk("mid_r2", read_data1, 16'h0000);
        chk("mid_r3", read_data2, 16'h0000);
        tick();
        step(1, 1, 3, 16'h1111, 0, 0, 0, 0, 0); tick();
        step(1, 0, 0, 0, 3, 3, 0, 0, 0);
        chk("resume_r3", read_data1, 16'h1111);
        tick();

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) != 0),
                 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 16'($urandom),
                 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)),
                 16'($urandom),
                 16'($urandom),
                 3'($urandom_range(0, 7)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
